// File: rtl/cache_pkg.sv
// Shared geometry, tag-entry layout and refill FSM states for the 8-set x 4-way cache.
package cache_pkg;
  localparam int NUM_SETS   = 8;
  localparam int NUM_WAYS   = 4;
  localparam int TAG_W      = 5;
  localparam int LINE_WORDS = 4;
  localparam int DATA_W     = 32;
  localparam int SET_W      = $clog2(NUM_SETS);
  localparam int WAY_W      = $clog2(NUM_WAYS);
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int ADDR_W     = TAG_W + SET_W + OFF_W;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_WR,
    FILL_REQ,
    FILL_DATA,
    TAG_UPD
  } refill_state_e;

  function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [SET_W-1:0] set,
                                                  input logic [OFF_W-1:0] word);
    return {tag, set, word};
  endfunction
endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss handler: optional dirty-victim writeback, line fetch into the data array, then tag install.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [SET_W-1:0]  miss_set,
  input  logic [TAG_W-1:0]  miss_tag,
  input  logic [WAY_W-1:0]  victim_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  output logic              evict_re,
  output logic [SET_W-1:0]  evict_set,
  output logic [WAY_W-1:0]  evict_way,
  output logic [OFF_W-1:0]  evict_word,
  input  logic [DATA_W-1:0] evict_rdata,
  output logic              fill_we,
  output logic [SET_W-1:0]  fill_set,
  output logic [WAY_W-1:0]  fill_way,
  output logic [OFF_W-1:0]  fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              tag_we,
  output logic [SET_W-1:0]  tag_set,
  output logic [WAY_W-1:0]  tag_way,
  output logic [TAG_W+1:0]  tag_value,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              refill_done
);

  refill_state_e     state_reg, state_next;
  logic [OFF_W-1:0]  word_reg, word_next;
  logic [SET_W-1:0]  set_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [TAG_W-1:0]  vtag_reg;
  logic [WAY_W-1:0]  way_reg;
  logic              first_wr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              last_word;
  tag_entry_t        new_entry;

  assign last_word = (word_reg == OFF_W'(LINE_WORDS - 1));
  assign new_entry = '{valid: 1'b1, dirty: 1'b0, tag: tag_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      set_reg      <= '0;
      tag_reg      <= '0;
      vtag_reg     <= '0;
      way_reg      <= '0;
      first_wr_reg <= 1'b0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      // Array read data arrives the cycle after WB_RD, i.e. in the first WB_WR cycle.
      first_wr_reg <= (state_reg == WB_RD);
      if (state_reg == IDLE && miss_valid) begin
        set_reg  <= miss_set;
        tag_reg  <= miss_tag;
        vtag_reg <= victim_tag;
        way_reg  <= victim_way;
      end
      if (state_reg == WB_WR && first_wr_reg) begin
        wdata_reg <= evict_rdata;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    miss_ready    = 1'b0;
    evict_re      = 1'b0;
    evict_set     = '0;
    evict_way     = '0;
    evict_word    = '0;
    fill_we       = 1'b0;
    fill_set      = '0;
    fill_way      = '0;
    fill_word     = '0;
    fill_data     = '0;
    tag_we        = 1'b0;
    tag_set       = '0;
    tag_way       = '0;
    tag_value     = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_wdata     = '0;
    refill_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          word_next  = '0;
          state_next = (victim_valid && victim_dirty) ? WB_RD : FILL_REQ;
        end
      end
      WB_RD: begin
        evict_re   = 1'b1;
        evict_set  = set_reg;
        evict_way  = way_reg;
        evict_word = word_reg;
        state_next = WB_WR;
      end
      WB_WR: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = make_addr(vtag_reg, set_reg, word_reg);
        mem_wdata     = first_wr_reg ? evict_rdata : wdata_reg;
        if (mem_req_ready) begin
          if (last_word) begin
            word_next  = '0;
            state_next = FILL_REQ;
          end else begin
            word_next  = word_reg + 1'b1;
            state_next = WB_RD;
          end
        end
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = make_addr(tag_reg, set_reg, '0);
        if (mem_req_ready) begin
          state_next = FILL_DATA;
        end
      end
      FILL_DATA: begin
        if (mem_rdata_valid) begin
          fill_we   = 1'b1;
          fill_set  = set_reg;
          fill_way  = way_reg;
          fill_word = word_reg;
          fill_data = mem_rdata;
          if (last_word) begin
            word_next  = '0;
            state_next = TAG_UPD;
          end else begin
            word_next = word_reg + 1'b1;
          end
        end
      end
      TAG_UPD: begin
        tag_we      = 1'b1;
        tag_set     = set_reg;
        tag_way     = way_reg;
        tag_value   = new_entry;
        refill_done = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: array/memory responders plus per-scenario checks.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic              clk, rst;
  logic              miss_valid, miss_ready;
  logic [SET_W-1:0]  miss_set;
  logic [TAG_W-1:0]  miss_tag;
  logic [WAY_W-1:0]  victim_way;
  logic              victim_valid, victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic              evict_re;
  logic [SET_W-1:0]  evict_set;
  logic [WAY_W-1:0]  evict_way;
  logic [OFF_W-1:0]  evict_word;
  logic [DATA_W-1:0] evict_rdata;
  logic              fill_we;
  logic [SET_W-1:0]  fill_set;
  logic [WAY_W-1:0]  fill_way;
  logic [OFF_W-1:0]  fill_word;
  logic [DATA_W-1:0] fill_data;
  logic              tag_we;
  logic [SET_W-1:0]  tag_set;
  logic [WAY_W-1:0]  tag_way;
  logic [TAG_W+1:0]  tag_value;
  logic              mem_req_valid, mem_req_ready, mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              refill_done;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_set(miss_set), .miss_tag(miss_tag),
    .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag),
    .evict_re(evict_re), .evict_set(evict_set), .evict_way(evict_way), .evict_word(evict_word),
    .evict_rdata(evict_rdata),
    .fill_we(fill_we), .fill_set(fill_set), .fill_way(fill_way), .fill_word(fill_word),
    .fill_data(fill_data),
    .tag_we(tag_we), .tag_set(tag_set), .tag_way(tag_way), .tag_value(tag_value),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .refill_done(refill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SET_W-1:0] set;
    logic [TAG_W-1:0] tag;
    logic [WAY_W-1:0] way;
    logic             vvalid;
    logic             vdirty;
    logic [TAG_W-1:0] vtag;
  } miss_t;
  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
  typedef struct {
    logic [SET_W-1:0]  set;
    logic [WAY_W-1:0]  way;
    logic [OFF_W-1:0]  word;
    logic [DATA_W-1:0] data;
  } fill_t;
  typedef struct {
    logic [SET_W-1:0] set;
    logic [WAY_W-1:0] way;
    logic [TAG_W+1:0] value;
  } tagw_t;

  miss_t miss_q[$];
  req_t  reqs[$];
  fill_t fills[$];
  tagw_t tagws[$];
  int    accept_cyc[$];
  int    done_cyc[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_wb_left, stall_fill_left, stall_seen, stray_idle_left, stray_hits, unstable;
  bit stray_on_wr;
  bit rd_pending;
  int beat_idx, rd_seq;
  logic [DATA_W-1:0] beat_base;
  bit                ev_pending;
  logic [SET_W-1:0]  ev_set;
  logic [WAY_W-1:0]  ev_way;
  logic [OFF_W-1:0]  ev_word;
  bit                prev_stalled;
  logic              prev_write;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_wdata;

  // Drive all DUT inputs for the coming cycle, shortly after the rising edge.
  task automatic update_inputs();
    if (miss_q.size() > 0) begin
      miss_valid   = 1'b1;
      miss_set     = miss_q[0].set;
      miss_tag     = miss_q[0].tag;
      victim_way   = miss_q[0].way;
      victim_valid = miss_q[0].vvalid;
      victim_dirty = miss_q[0].vdirty;
      victim_tag   = miss_q[0].vtag;
    end else begin
      miss_valid   = 1'b0;
      miss_set     = SET_W'($urandom);
      miss_tag     = TAG_W'($urandom);
      victim_way   = WAY_W'($urandom);
      victim_valid = 1'($urandom);
      victim_dirty = 1'($urandom);
      victim_tag   = TAG_W'($urandom);
    end
    if (ev_pending) evict_rdata = {8'hD0, 8'(ev_set), 8'(ev_way), 8'(ev_word)};
    else            evict_rdata = 32'hBAD0_0000 + 32'(cyc);
    mem_req_ready = 1'b1;
    if (mem_req_valid && mem_req_write && mem_req_addr[1:0] == 2'd2 && stall_wb_left > 0) begin
      mem_req_ready = 1'b0;
      stall_wb_left--;
      stall_seen++;
    end else if (mem_req_valid && !mem_req_write && stall_fill_left > 0) begin
      mem_req_ready = 1'b0;
      stall_fill_left--;
      stall_seen++;
    end
    mem_rdata_valid = 1'b0;
    mem_rdata       = 32'h5555_0000 + 32'(cyc);
    if (rd_pending) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = beat_base + 32'((rd_seq - 1) * 256 + beat_idx);
      beat_idx++;
      if (beat_idx == LINE_WORDS) rd_pending = 1'b0;
    end else if (stray_idle_left > 0) begin
      mem_rdata_valid = 1'b1;
      stray_idle_left--;
    end else if (stray_on_wr && mem_req_valid && mem_req_write) begin
      mem_rdata_valid = 1'b1;
      stray_on_wr     = 1'b0;
      stray_hits++;
    end
  endtask

  // Observe DUT outputs on the falling edge and log handshakes.
  task automatic sample();
    cyc++;
    ev_pending = evict_re;
    ev_set     = evict_set;
    ev_way     = evict_way;
    ev_word    = evict_word;
    if (prev_stalled && (mem_req_valid !== 1'b1 || mem_req_write !== prev_write ||
                         mem_req_addr !== prev_addr || mem_wdata !== prev_wdata))
      unstable++;
    prev_stalled = mem_req_valid && !mem_req_ready;
    prev_write   = mem_req_write;
    prev_addr    = mem_req_addr;
    prev_wdata   = mem_wdata;
    if (mem_req_valid && mem_req_ready) begin
      reqs.push_back('{write: mem_req_write, addr: mem_req_addr, wdata: mem_wdata});
      if (!mem_req_write) begin
        rd_pending = 1'b1;
        beat_idx   = 0;
        rd_seq++;
      end
    end
    if (fill_we) fills.push_back('{set: fill_set, way: fill_way, word: fill_word, data: fill_data});
    if (tag_we) tagws.push_back('{set: tag_set, way: tag_way, value: tag_value});
    if (refill_done) done_cyc.push_back(cyc);
    if (miss_valid && miss_ready) begin
      accept_cyc.push_back(cyc);
      void'(miss_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    update_inputs();
    @(negedge clk);
    sample();
  endtask

  task automatic clear_logs();
    reqs.delete(); fills.delete(); tagws.delete(); accept_cyc.delete(); done_cyc.delete();
    stall_wb_left = 0; stall_fill_left = 0; stall_seen = 0; stray_idle_left = 0;
    stray_hits = 0; stray_on_wr = 1'b0; unstable = 0; rd_pending = 1'b0; beat_idx = 0;
    rd_seq = 0; prev_stalled = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n = 0;
    while (done_cyc.size() < target && n < budget) begin
      step();
      n++;
    end
    total++;
    if (done_cyc.size() < target) begin
      bad++;
      $display("FAIL %s_timeout: refill_done count %0d, required %0d within %0d cycles",
               name, done_cyc.size(), target, budget);
    end
  endtask

  task automatic check_fills(input string name, input int first, input logic [SET_W-1:0] set,
                             input logic [WAY_W-1:0] way, input logic [DATA_W-1:0] base);
    for (int k = 0; k < LINE_WORDS; k++) begin
      total++;
      if (fills.size() <= first + k) begin
        bad++;
        $display("FAIL %s_fill%0d: missing, have %0d fills", name, k, fills.size());
      end else if ({fills[first+k].set, fills[first+k].way, fills[first+k].word, fills[first+k].data}
                   !== {set, way, OFF_W'(k), base + 32'(k)}) begin
        bad++;
        $display("FAIL %s_fill%0d: got set=%0d way=%0d word=%0d data=%h, want set=%0d way=%0d word=%0d data=%h",
                 name, k, fills[first+k].set, fills[first+k].way, fills[first+k].word,
                 fills[first+k].data, set, way, k, base + 32'(k));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({miss_ready, evict_re, fill_we, tag_we, mem_req_valid, mem_req_write, refill_done} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {miss_ready, evict_re, fill_we, tag_we, mem_req_valid, mem_req_write, refill_done});
    end
    total++;
    if ({mem_req_addr, mem_wdata, fill_data, tag_value, evict_set, evict_way, evict_word,
         fill_set, fill_way, fill_word, tag_set, tag_way} !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h wdata=%h fill_data=%h tag_value=%h, want all 0",
               mem_req_addr, mem_wdata, fill_data, tag_value);
    end
    rst = 1'b0;
    step();
    step();
    total++;
    if (miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle_ready: got %b want 1", miss_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_miss();
    clear_logs();
    beat_base = 32'hA000_0000;
    miss_q.push_back('{set: 3'd3, tag: 5'h12, way: 2'd2, vvalid: 1'b0, vdirty: 1'b1, vtag: 5'h1F});
    run_until(1, 60, "clean");
    repeat (3) step();
    total++;
    if (reqs.size() !== 1 || {reqs[0].write, reqs[0].addr} !== {1'b0, 10'h24C}) begin
      bad++;
      $display("FAIL clean_req: count=%0d first write=%b addr=%h, want 1 read at 24c",
               reqs.size(), reqs[0].write, reqs[0].addr);
    end
    total++;
    if (fills.size() !== LINE_WORDS) begin
      bad++;
      $display("FAIL clean_fill_count: got %0d want 4", fills.size());
    end
    check_fills("clean", 0, 3'd3, 2'd2, 32'hA000_0000);
    total++;
    if (tagws.size() !== 1 || {tagws[0].set, tagws[0].way, tagws[0].value} !== {3'd3, 2'd2, 7'b1_0_10010}) begin
      bad++;
      $display("FAIL clean_tag: count=%0d set=%0d way=%0d value=%b, want 1 write set=3 way=2 value=1010010",
               tagws.size(), tagws[0].set, tagws[0].way, tagws[0].value);
    end
    total++;
    if (done_cyc.size() !== 1 || done_cyc[0] - accept_cyc[0] !== 6) begin
      bad++;
      $display("FAIL clean_done: pulses=%0d latency=%0d, want 1 pulse latency 6",
               done_cyc.size(), done_cyc[0] - accept_cyc[0]);
    end
    $display("test_clean_miss done: reqs=%0d fills=%0d", reqs.size(), fills.size());
  endtask

  task automatic test_dirty_miss();
    clear_logs();
    beat_base = 32'hB000_0000;
    miss_q.push_back('{set: 3'd1, tag: 5'h0A, way: 2'd0, vvalid: 1'b1, vdirty: 1'b1, vtag: 5'h07});
    run_until(1, 80, "dirty");
    total++;
    if (reqs.size() !== 5) begin
      bad++;
      $display("FAIL dirty_req_count: got %0d want 5", reqs.size());
    end
    for (int k = 0; k < LINE_WORDS && k < reqs.size(); k++) begin
      total++;
      if ({reqs[k].write, reqs[k].addr, reqs[k].wdata} !== {1'b1, 10'h0E4 + 10'(k), 32'hD001_0000 + 32'(k)}) begin
        bad++;
        $display("FAIL dirty_wb%0d: got write=%b addr=%h data=%h, want write=1 addr=%h data=%h",
                 k, reqs[k].write, reqs[k].addr, reqs[k].wdata, 10'h0E4 + 10'(k), 32'hD001_0000 + 32'(k));
      end
    end
    total++;
    if (reqs.size() < 5 || {reqs[4].write, reqs[4].addr} !== {1'b0, 10'h144}) begin
      bad++;
      $display("FAIL dirty_read: got last write=%b addr=%h, want read at 144",
               reqs[reqs.size()-1].write, reqs[reqs.size()-1].addr);
    end
    check_fills("dirty", 0, 3'd1, 2'd0, 32'hB000_0000);
    total++;
    if (tagws.size() !== 1 || tagws[0].value !== 7'b1_0_01010 || done_cyc[0] - accept_cyc[0] !== 14) begin
      bad++;
      $display("FAIL dirty_tag: count=%0d value=%b latency=%0d, want 1 value=1001010 latency 14",
               tagws.size(), tagws[0].value, done_cyc[0] - accept_cyc[0]);
    end
    $display("test_dirty_miss done: reqs=%0d fills=%0d", reqs.size(), fills.size());
  endtask

  task automatic test_stall();
    clear_logs();
    beat_base = 32'hC000_0000;
    stall_wb_left   = 5;
    stall_fill_left = 5;
    miss_q.push_back('{set: 3'd6, tag: 5'h03, way: 2'd3, vvalid: 1'b1, vdirty: 1'b1, vtag: 5'h1F});
    run_until(1, 100, "stall");
    total++;
    if (reqs.size() !== 5 || stall_seen !== 10 || unstable !== 0) begin
      bad++;
      $display("FAIL stall_handshake: reqs=%0d stalls=%0d unstable=%0d, want 5 10 0",
               reqs.size(), stall_seen, unstable);
    end
    for (int k = 0; k < LINE_WORDS && k < reqs.size(); k++) begin
      total++;
      if ({reqs[k].write, reqs[k].addr, reqs[k].wdata} !== {1'b1, 10'h3F8 + 10'(k), 32'hD006_0300 + 32'(k)}) begin
        bad++;
        $display("FAIL stall_wb%0d: got write=%b addr=%h data=%h, want write=1 addr=%h data=%h",
                 k, reqs[k].write, reqs[k].addr, reqs[k].wdata, 10'h3F8 + 10'(k), 32'hD006_0300 + 32'(k));
      end
    end
    total++;
    if (reqs.size() < 5 || {reqs[4].write, reqs[4].addr} !== {1'b0, 10'h078}) begin
      bad++;
      $display("FAIL stall_read: got write=%b addr=%h, want read at 078",
               reqs[reqs.size()-1].write, reqs[reqs.size()-1].addr);
    end
    check_fills("stall", 0, 3'd6, 2'd3, 32'hC000_0000);
    total++;
    if (done_cyc[0] - accept_cyc[0] !== 24) begin
      bad++;
      $display("FAIL stall_latency: got %0d want 24", done_cyc[0] - accept_cyc[0]);
    end
    $display("test_stall done: stalls=%0d", stall_seen);
  endtask

  task automatic test_stray();
    clear_logs();
    stray_idle_left = 3;
    repeat (4) step();
    total++;
    if (fills.size() !== 0 || reqs.size() !== 0 || miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL stray_idle: fills=%0d reqs=%0d miss_ready=%b, want 0 0 1",
               fills.size(), reqs.size(), miss_ready);
    end
    beat_base   = 32'hE000_0000;
    stray_on_wr = 1'b1;
    miss_q.push_back('{set: 3'd5, tag: 5'h11, way: 2'd1, vvalid: 1'b1, vdirty: 1'b1, vtag: 5'h02});
    run_until(1, 80, "stray");
    total++;
    if (stray_hits !== 1 || fills.size() !== LINE_WORDS || reqs.size() !== 5) begin
      bad++;
      $display("FAIL stray_wb: stray_beats=%0d fills=%0d reqs=%0d, want 1 4 5",
               stray_hits, fills.size(), reqs.size());
    end
    check_fills("stray", 0, 3'd5, 2'd1, 32'hE000_0000);
    total++;
    if (tagws.size() !== 1 || {tagws[0].set, tagws[0].way, tagws[0].value} !== {3'd5, 2'd1, 7'b1_0_10001}) begin
      bad++;
      $display("FAIL stray_tag: count=%0d value=%b, want 1 value=1010001", tagws.size(), tagws[0].value);
    end
    $display("test_stray done");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    beat_base = 32'h7000_0000;
    miss_q.push_back('{set: 3'd2, tag: 5'h0C, way: 2'd1, vvalid: 1'b0, vdirty: 1'b0, vtag: 5'h00});
    while (fills.size() < 2 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (fills.size() !== 2) begin
      bad++;
      $display("FAIL rstmid_setup: fills=%0d want 2 before reset", fills.size());
    end
    rst = 1'b1;
    #1;
    total++;
    if ({miss_ready, evict_re, fill_we, tag_we, mem_req_valid, refill_done} !== 6'b100000) begin
      bad++;
      $display("FAIL rstmid_outputs: got %b want 100000",
               {miss_ready, evict_re, fill_we, tag_we, mem_req_valid, refill_done});
    end
    rd_pending = 1'b0;
    repeat (2) step();
    total++;
    if (tagws.size() !== 0 || done_cyc.size() !== 0 || fills.size() !== 2) begin
      bad++;
      $display("FAIL rstmid_aborted: tag_writes=%0d dones=%0d fills=%0d, want 0 0 2",
               tagws.size(), done_cyc.size(), fills.size());
    end
    rst = 1'b0;
    clear_logs();
    beat_base = 32'hF000_0000;
    miss_q.push_back('{set: 3'd2, tag: 5'h0C, way: 2'd1, vvalid: 1'b1, vdirty: 1'b0, vtag: 5'h1F});
    run_until(1, 60, "rstmid");
    total++;
    if (reqs.size() !== 1 || {reqs[0].write, reqs[0].addr} !== {1'b0, 10'h188}) begin
      bad++;
      $display("FAIL rstmid_req: count=%0d write=%b addr=%h, want 1 read at 188",
               reqs.size(), reqs[0].write, reqs[0].addr);
    end
    check_fills("rstmid", 0, 3'd2, 2'd1, 32'hF000_0000);
    total++;
    if (tagws.size() !== 1 || tagws[0].value !== 7'b1_0_01100) begin
      bad++;
      $display("FAIL rstmid_tag: count=%0d value=%b, want 1 value=1001100", tagws.size(), tagws[0].value);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    clear_logs();
    beat_base = 32'h3000_0000;
    miss_q.push_back('{set: 3'd4, tag: 5'h15, way: 2'd3, vvalid: 1'b1, vdirty: 1'b0, vtag: 5'h01});
    miss_q.push_back('{set: 3'd7, tag: 5'h09, way: 2'd0, vvalid: 1'b0, vdirty: 1'b0, vtag: 5'h02});
    run_until(2, 80, "b2b");
    total++;
    if (accept_cyc.size() !== 2 || done_cyc.size() !== 2 || accept_cyc[1] !== done_cyc[0] + 1) begin
      bad++;
      $display("FAIL b2b_accept: accepts=%0d dones=%0d second_accept=%0d, want 2 2 %0d",
               accept_cyc.size(), done_cyc.size(), accept_cyc[1], done_cyc[0] + 1);
    end
    total++;
    if (reqs.size() !== 2 || reqs[0].addr !== 10'h2B0 || reqs[1].addr !== 10'h13C) begin
      bad++;
      $display("FAIL b2b_reqs: count=%0d addr0=%h addr1=%h, want 2 2b0 13c",
               reqs.size(), reqs[0].addr, reqs[1].addr);
    end
    check_fills("b2b_a", 0, 3'd4, 2'd3, 32'h3000_0000);
    check_fills("b2b_b", 4, 3'd7, 2'd0, 32'h3000_0100);
    total++;
    if (tagws.size() !== 2 || {tagws[0].set, tagws[0].way, tagws[0].value} !== {3'd4, 2'd3, 7'b1_0_10101} ||
        {tagws[1].set, tagws[1].way, tagws[1].value} !== {3'd7, 2'd0, 7'b1_0_01001}) begin
      bad++;
      $display("FAIL b2b_tags: count=%0d v0=%b v1=%b, want 2 1010101 1001001",
               tagws.size(), tagws[0].value, tagws[1].value);
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    miss_valid = 1'b0; miss_set = '0; miss_tag = '0; victim_way = '0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    evict_rdata = '0; mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    ev_pending = 1'b0; ev_set = '0; ev_way = '0; ev_word = '0;
    prev_write = 1'b0; prev_addr = '0; prev_wdata = '0;
    beat_base = '0;
    clear_logs();
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stall();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
